// File: rtl/host_cmd_packet_sequencer_pkg.sv
// Shared definitions for the host command packet sequencer: command codes,
// error codes and FSM state encoding.
package host_cmd_packet_sequencer_pkg;

  // Host command codes carried in the decoded command word.
  localparam int unsigned CmdEncOn  = 1;
  localparam int unsigned CmdEncOff = 2;
  localparam int unsigned CmdStatus = 3;

  typedef enum logic [1:0] {
    ErrNone       = 2'b00,
    ErrDecode     = 2'b01,
    ErrUnknownCmd = 2'b10,
    ErrTimeout    = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StDecWait,
    StEncWait,
    StBleWait,
    StOutput,
    StMode
  } state_e;

endpackage

// File: rtl/host_cmd_packet_sequencer_if.sv
// Valid/ready stream bundle used for the host frame input and the packet output.
interface host_cmd_packet_sequencer_if #(
  parameter int unsigned W = 8
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/host_cmd_packet_sequencer_sync_frame_fifo.sv
// Synchronous frame FIFO with first-word fall-through read data.
module sync_frame_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  // Push is refused when full even if a pop happens in the same cycle.
  always_comb begin
    do_push = push && (count_q != (PtrW+1)'(DEPTH));
    do_pop  = pop && (count_q != '0);
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PtrW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (PtrW+1)'(1);
    end
  end

  // Status flags and head-of-queue data.
  always_comb begin
    rdata = mem_q[rd_ptr_q];
    full  = (count_q == (PtrW+1)'(DEPTH));
    empty = (count_q == '0);
    count = count_q;
  end

endmodule

// File: rtl/host_cmd_packet_sequencer.sv
// Queues host frames and walks each through decode -> encrypt -> BLE encode,
// then presents the packet on a valid/ready output and applies the mode change.
module host_cmd_packet_sequencer
  import host_cmd_packet_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_W    = 1024,
  parameter int unsigned CMD_W      = 16,
  parameter int unsigned PAYLOAD_W  = 32,
  parameter int unsigned PKT_W      = 144,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [3:0]  BLE_TX_CMD = 4'h1
) (
  input  logic                 clk,
  input  logic                 reset,
  host_cmd_packet_sequencer_if.slave  in_if,
  output logic                 dec_start,
  output logic [FRAME_W-1:0]   dec_frame,
  input  logic                 dec_done,
  input  logic                 dec_error,
  input  logic [CMD_W-1:0]     dec_cmd,
  output logic                 enc_start,
  output logic [CMD_W-1:0]     enc_data,
  input  logic                 enc_done,
  input  logic [CMD_W-1:0]     enc_result,
  output logic                 ble_start,
  output logic [PAYLOAD_W-1:0] ble_data,
  output logic [3:0]           ble_cmd,
  input  logic                 ble_done,
  input  logic [PKT_W-1:0]     ble_packet,
  host_cmd_packet_sequencer_if.master pkt_if,
  output logic                 passthrough,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic                 busy
);
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 dec_start_q, dec_start_d, enc_start_q, enc_start_d;
  logic                 ble_start_q, ble_start_d;
  logic [FRAME_W-1:0]   dec_frame_q, dec_frame_d;
  logic [CMD_W-1:0]     cmd_q, cmd_d, result_q, result_d;
  logic [PKT_W-1:0]     pkt_out_q, pkt_out_d;
  logic                 pkt_valid_q, pkt_valid_d, pt_q, pt_d, err_q, err_d;
  err_code_e            err_code_q, err_code_d;
  logic                 fifo_pop, fifo_full, fifo_empty, cmd_known, timed_out;
  logic [FRAME_W-1:0]   fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;

  sync_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_if.valid),
    .pop   (fifo_pop),
    .wdata (in_if.data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state and datapath updates; a done always beats a same-cycle expiry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dec_start_d = 1'b0;
    enc_start_d = 1'b0;
    ble_start_d = 1'b0;
    dec_frame_d = dec_frame_q;
    cmd_d       = cmd_q;
    result_d    = result_q;
    pkt_out_d   = pkt_out_q;
    pkt_valid_d = pkt_valid_q;
    pt_d        = pt_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    fifo_pop    = 1'b0;
    cmd_known   = (dec_cmd == CMD_W'(CmdEncOn)) || (dec_cmd == CMD_W'(CmdEncOff)) ||
                  (dec_cmd == CMD_W'(CmdStatus));
    timed_out   = (cnt_q == CntLast);
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          dec_frame_d = fifo_rdata;
          dec_start_d = 1'b1;
          err_code_d  = ErrNone;
          cnt_d       = '0;
          state_d     = StDecWait;
        end
      end
      StDecWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (dec_done) begin
          if (dec_error) begin
            err_d      = 1'b1;
            err_code_d = ErrDecode;
            state_d    = StIdle;
          end else if (!cmd_known) begin
            err_d      = 1'b1;
            err_code_d = ErrUnknownCmd;
            state_d    = StIdle;
          end else begin
            cmd_d       = dec_cmd;
            enc_start_d = 1'b1;
            cnt_d       = '0;
            state_d     = StEncWait;
          end
        end else if (timed_out) begin
          err_d      = 1'b1;
          err_code_d = ErrTimeout;
          state_d    = StIdle;
        end
      end
      StEncWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (enc_done) begin
          result_d    = enc_result;
          ble_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = StBleWait;
        end else if (timed_out) begin
          err_d      = 1'b1;
          err_code_d = ErrTimeout;
          state_d    = StIdle;
        end
      end
      StBleWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (ble_done) begin
          pkt_out_d   = ble_packet;
          pkt_valid_d = 1'b1;
          state_d     = StOutput;
        end else if (timed_out) begin
          err_d      = 1'b1;
          err_code_d = ErrTimeout;
          state_d    = StIdle;
        end
      end
      StOutput: begin
        // Transport may stall indefinitely here.
        if (pkt_if.ready) begin
          pkt_valid_d = 1'b0;
          state_d     = StMode;
        end
      end
      StMode: begin
        // Mode changes only after the acknowledging packet has left.
        if (cmd_q == CMD_W'(CmdEncOn))       pt_d = 1'b0;
        else if (cmd_q == CMD_W'(CmdEncOff)) pt_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight frame silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dec_start_q <= 1'b0;
      enc_start_q <= 1'b0;
      ble_start_q <= 1'b0;
      dec_frame_q <= '0;
      cmd_q       <= '0;
      result_q    <= '0;
      pkt_out_q   <= '0;
      pkt_valid_q <= 1'b0;
      pt_q        <= 1'b1;
      err_q       <= 1'b0;
      err_code_q  <= ErrNone;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dec_start_q <= dec_start_d;
      enc_start_q <= enc_start_d;
      ble_start_q <= ble_start_d;
      dec_frame_q <= dec_frame_d;
      cmd_q       <= cmd_d;
      result_q    <= result_d;
      pkt_out_q   <= pkt_out_d;
      pkt_valid_q <= pkt_valid_d;
      pt_q        <= pt_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Output mapping.
  always_comb begin
    in_if.ready  = !fifo_full;
    dec_start    = dec_start_q;
    dec_frame    = dec_frame_q;
    enc_start    = enc_start_q;
    enc_data     = cmd_q;
    ble_start    = ble_start_q;
    ble_data     = {{(PAYLOAD_W - CMD_W){1'b0}}, result_q};
    ble_cmd      = (state_q == StBleWait) ? BLE_TX_CMD : 4'h0;
    pkt_if.data  = pkt_out_q;
    pkt_if.valid = pkt_valid_q;
    passthrough  = pt_q;
    err          = err_q;
    err_code     = err_code_q;
    busy         = (state_q != StIdle) || (fifo_count != '0);
  end

endmodule

// File: tb/tb_host_cmd_packet_sequencer.sv
// Self-checking bench: stage stubs, a table of single-frame vectors and
// hand-written sequences for timeout, back-pressure and mid-flight reset.
module tb_host_cmd_packet_sequencer;
  localparam int unsigned FRAME_W = 1024, CMD_W = 16, PAYLOAD_W = 32, PKT_W = 144;
  localparam int unsigned DEPTH = 4, TIMEOUT = 8;
  localparam logic [FRAME_W-1:0] Fill = {32{32'hC0FFEE11}};

  logic clk = 1'b0, reset;
  logic dec_start, dec_done, dec_error, enc_start, enc_done, ble_start, ble_done;
  logic passthrough, err, busy;
  logic [FRAME_W-1:0] dec_frame;
  logic [CMD_W-1:0] dec_cmd, enc_data, enc_result;
  logic [PAYLOAD_W-1:0] ble_data;
  logic [3:0] ble_cmd;
  logic [PKT_W-1:0] ble_packet;
  logic [1:0] err_code;

  host_cmd_packet_sequencer_if #(.W(FRAME_W)) in_if ();
  host_cmd_packet_sequencer_if #(.W(PKT_W))   pkt_if ();

  host_cmd_packet_sequencer #(
    .FRAME_W (FRAME_W), .CMD_W (CMD_W), .PAYLOAD_W (PAYLOAD_W), .PKT_W (PKT_W),
    .DEPTH (DEPTH), .TIMEOUT (TIMEOUT), .BLE_TX_CMD (4'h1)
  ) dut (
    .clk (clk), .reset (reset), .in_if (in_if),
    .dec_start (dec_start), .dec_frame (dec_frame), .dec_done (dec_done),
    .dec_error (dec_error), .dec_cmd (dec_cmd),
    .enc_start (enc_start), .enc_data (enc_data), .enc_done (enc_done),
    .enc_result (enc_result),
    .ble_start (ble_start), .ble_data (ble_data), .ble_cmd (ble_cmd),
    .ble_done (ble_done), .ble_packet (ble_packet),
    .pkt_if (pkt_if), .passthrough (passthrough), .err (err), .err_code (err_code),
    .busy (busy)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int n_dec = 0, n_enc = 0, n_ble = 0, n_err = 0;
  logic [PKT_W-1:0] got_q [$];
  logic enc_hang = 1'b0;
  int enc_delay = 2;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pkt(input string name, input logic [PKT_W-1:0] act,
                           input logic [PKT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] exp_pkt(input logic [15:0] data);
    exp_pkt = {108'd0, 4'h1, 16'h0000, data};
  endfunction

  // Decoder stub: done two negedges after the start pulse, cmd from frame bits.
  initial begin
    dec_done = 1'b0; dec_error = 1'b0; dec_cmd = '0;
    forever begin
      @(negedge clk);
      dec_done = 1'b0;
      if (dec_start) begin
        repeat (2) @(negedge clk);
        dec_cmd = dec_frame[15:0]; dec_error = dec_frame[16]; dec_done = 1'b1;
      end
    end
  end

  // Encrypt stub: XOR key applied only when passthrough is off.
  initial begin
    enc_done = 1'b0; enc_result = '0;
    forever begin
      @(negedge clk);
      enc_done = 1'b0;
      if (enc_start && !enc_hang) begin
        repeat (enc_delay) @(negedge clk);
        enc_result = enc_data ^ (passthrough ? 16'h0000 : 16'hA5A5);
        enc_done = 1'b1;
      end
    end
  end

  // BLE stub: packet records the command select and payload it saw.
  initial begin
    ble_done = 1'b0; ble_packet = '0;
    forever begin
      @(negedge clk);
      ble_done = 1'b0;
      if (ble_start) begin
        repeat (2) @(negedge clk);
        ble_packet = {108'd0, ble_cmd, ble_data}; ble_done = 1'b1;
      end
    end
  end

  // Monitor: pulse counts, accepted packets, output hold/stability while stalled.
  initial begin
    logic pv;
    logic [PKT_W-1:0] pp;
    pv = 1'b0; pp = '0;
    forever begin
      @(negedge clk); #1;
      n_dec += int'(dec_start); n_enc += int'(enc_start);
      n_ble += int'(ble_start); n_err += int'(err);
      if (pv && !reset) begin
        check("pkt_valid_held", int'(pkt_if.valid), 1);
        check_pkt("pkt_out_stable", pkt_if.data, pp);
      end
      if (pkt_if.valid && pkt_if.ready) begin
        got_q.push_back(pkt_if.data);
        pv = 1'b0;
      end else begin
        pv = pkt_if.valid; pp = pkt_if.data;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [16:0] lo);
    int k;
    in_if.data = {Fill[FRAME_W-1:17], lo};
    in_if.valid = 1'b1;
    k = 0;
    while (!in_ready_now() && k < 200) begin @(negedge clk); k++; end
    check("push_accepted", int'(in_ready_now()), 1);
    @(negedge clk);
    in_if.valid = 1'b0;
  endtask

  function automatic logic in_ready_now();
    in_ready_now = in_if.ready;
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 300) begin @(negedge clk); k++; end
    check("wait_idle", int'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dec_start"}, int'(dec_start), 0);
    check({tag, "_enc_start"}, int'(enc_start), 0);
    check({tag, "_ble_start"}, int'(ble_start), 0);
    check({tag, "_pkt_valid"}, int'(pkt_if.valid), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_err_code"}, int'(err_code), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_in_ready"}, int'(in_if.ready), 1);
    check({tag, "_passthrough"}, int'(passthrough), 1);
    check({tag, "_dec_frame_zero"}, int'(dec_frame != '0), 0);
    check({tag, "_enc_data"}, int'(enc_data), 0);
    check({tag, "_ble_data"}, int'(ble_data), 0);
    check({tag, "_ble_cmd"}, int'(ble_cmd), 0);
    check_pkt({tag, "_pkt_out"}, pkt_if.data, '0);
  endtask

  typedef struct {
    logic [16:0] lo;     // {dec_error, cmd}
    logic [1:0]  code;
    logic        pt;
    logic        pkt;
    logic [15:0] data;
  } vec_t;

  vec_t vt [8];

  initial begin
    int e0, d0, g0, r0, b0, lat;
    logic pt_m;
    logic [15:0] exp_data [5];
    int bp_cmd [5];

    vt[0] = '{17'h00002, 2'b00, 1'b1, 1'b1, 16'h0002};
    vt[1] = '{17'h00001, 2'b00, 1'b0, 1'b1, 16'h0001};
    vt[2] = '{17'h00003, 2'b00, 1'b0, 1'b1, 16'hA5A6};
    vt[3] = '{17'h10002, 2'b01, 1'b0, 1'b0, 16'h0000};
    vt[4] = '{17'h00007, 2'b10, 1'b0, 1'b0, 16'h0000};
    vt[5] = '{17'h00002, 2'b00, 1'b1, 1'b1, 16'hA5A7};
    vt[6] = '{17'h00003, 2'b00, 1'b1, 1'b1, 16'h0003};
    vt[7] = '{17'h00000, 2'b10, 1'b1, 1'b0, 16'h0000};
    bp_cmd = '{1, 2, 1, 2, 1};

    reset = 1'b1; in_if.valid = 1'b0; in_if.data = '0; pkt_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single-frame vectors, applied in order (mode state carries across them).
    for (int i = 0; i < 8; i++) begin
      e0 = n_enc; d0 = n_dec; g0 = got_q.size(); r0 = n_err;
      push(vt[i].lo);
      wait_idle();
      check($sformatf("v%0d_dec_starts", i), n_dec - d0, 1);
      check($sformatf("v%0d_enc_starts", i), n_enc - e0, int'(vt[i].pkt));
      check($sformatf("v%0d_err_pulses", i), n_err - r0, int'(vt[i].code != 2'b00));
      check($sformatf("v%0d_err_code", i), int'(err_code), int'(vt[i].code));
      check($sformatf("v%0d_passthrough", i), int'(passthrough), int'(vt[i].pt));
      check($sformatf("v%0d_pkt_count", i), got_q.size() - g0, int'(vt[i].pkt));
      if (vt[i].pkt && got_q.size() > 0)
        check_pkt($sformatf("v%0d_pkt", i), got_q[got_q.size()-1], exp_pkt(vt[i].data));
    end

    // Encrypt never answers: error must appear exactly TIMEOUT cycles after enc_start.
    enc_hang = 1'b1; r0 = n_err; g0 = got_q.size(); b0 = n_ble;
    push(17'h00001);
    begin
      int k;
      k = 0;
      while (!enc_start && k < 100) begin @(negedge clk); k++; end
      check("to_enc_start_seen", int'(enc_start), 1);
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (err && lat < 0) begin
        lat = i;
        check("to_busy_at_err", int'(busy), 0);
      end
    end
    check("to_latency", lat, int'(TIMEOUT));
    check("to_err_code", int'(err_code), 3);
    check("to_err_pulses", n_err - r0, 1);
    check("to_no_ble_start", n_ble - b0, 0);
    check("to_no_pkt", got_q.size() - g0, 0);
    check("to_passthrough", int'(passthrough), 1);
    enc_hang = 1'b0;

    // Done arriving in the expiry cycle must win over the timeout.
    enc_delay = int'(TIMEOUT) - 1; r0 = n_err; g0 = got_q.size();
    push(17'h00002);
    wait_idle();
    enc_delay = 2;
    check("dw_no_err", n_err - r0, 0);
    check("dw_err_code", int'(err_code), 0);
    check("dw_pkt_count", got_q.size() - g0, 1);
    if (got_q.size() > 0) check_pkt("dw_pkt", got_q[got_q.size()-1], exp_pkt(16'h0002));

    // Back-pressure: five frames with the transport stalled.
    pt_m = 1'b1;
    for (int j = 0; j < 5; j++) begin
      exp_data[j] = 16'(bp_cmd[j]) ^ (pt_m ? 16'h0000 : 16'hA5A5);
      if (bp_cmd[j] == 1) pt_m = 1'b0;
      else if (bp_cmd[j] == 2) pt_m = 1'b1;
    end
    pkt_if.ready = 1'b0; g0 = got_q.size();
    for (int j = 0; j < 5; j++) push({1'b0, 16'(bp_cmd[j])});
    check("bp_in_ready_full", int'(in_if.ready), 0);
    repeat (20) @(negedge clk);
    check("bp_in_ready_still_full", int'(in_if.ready), 0);
    check("bp_pkt_valid_stalled", int'(pkt_if.valid), 1);
    check("bp_no_pkt_yet", got_q.size() - g0, 0);
    check_pkt("bp_pkt_out_first", pkt_if.data, exp_pkt(exp_data[0]));
    pkt_if.ready = 1'b1;
    wait_idle();
    check("bp_pkt_count", got_q.size() - g0, 5);
    for (int j = 0; j < 5; j++)
      if (g0 + j < got_q.size())
        check_pkt($sformatf("bp_pkt%0d", j), got_q[g0+j], exp_pkt(exp_data[j]));
    check("bp_passthrough", int'(passthrough), int'(pt_m));

    // Asynchronous reset while waiting on the BLE encoder.
    r0 = n_err;
    push(17'h00003);
    begin
      int k;
      k = 0;
      while (!ble_start && k < 100) begin @(negedge clk); k++; end
      check("rst_ble_start_seen", int'(ble_start), 1);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    repeat (3) @(negedge clk);
    reset = 1'b0; g0 = got_q.size();
    repeat (10) @(negedge clk);
    check("midrst_no_err", n_err - r0, 0);
    check("midrst_no_pkt", got_q.size() - g0, 0);
    check("midrst_idle", int'(busy), 0);
    check("midrst_passthrough", int'(passthrough), 1);

    // Recovery after reset: a status frame goes through unencrypted.
    push(17'h00003);
    wait_idle();
    check("post_pkt_count", got_q.size() - g0, 1);
    if (got_q.size() > 0) check_pkt("post_pkt", got_q[got_q.size()-1], exp_pkt(16'h0003));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
